// File: rtl/serial_pattern_generator.sv
// Serial pattern transmitter: captures a parallel word on start and emits its low L bits MSB first.
// Optional continuous-repeat mode is compiled in with `define SEQ_GEN_REPEAT_EN (adds input repeat_en).
module serial_pattern_generator #(
    parameter int WIDTH = 44,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] length,
`ifdef SEQ_GEN_REPEAT_EN
    input  logic             repeat_en,
`endif
    output logic             X,
    output logic             x_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] bits_left
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] load_word;
    logic             load;

    logic             x_q, x_d;
    logic             x_valid_q, x_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] bits_left_q, bits_left_d;

`ifdef SEQ_GEN_REPEAT_EN
    logic [WIDTH-1:0] saved_word_q, saved_word_d;
    logic [CNT_W-1:0] saved_len_q, saved_len_d;
    logic             rep_first_q, rep_first_d;
`endif

    // Zero or out-of-range lengths fall back to the full word.
    always_comb begin
        if (length == '0 || length > CNT_W'(WIDTH)) begin
            eff_len = CNT_W'(WIDTH);
        end else begin
            eff_len = length;
        end
        shamt     = CNT_W'(WIDTH) - eff_len;
        load_word = pattern << shamt;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
        saved_word_d = saved_word_q;
        saved_len_d  = saved_len_q;
        rep_first_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (cnt_q == CNT_W'(1)) begin
`ifdef SEQ_GEN_REPEAT_EN
                    if (repeat_en) begin
                        shreg_d     = saved_word_q;
                        cnt_d       = saved_len_q;
                        rep_first_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
`else
                    state_d = DONE;
`endif
                end else begin
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (start) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load) begin
            shreg_d = load_word;
            cnt_d   = eff_len;
            state_d = SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
            saved_word_d = load_word;
            saved_len_d  = eff_len;
`endif
        end
    end

    // Outputs are re-registered from the current state, so they trail the state by one cycle.
    always_comb begin
        x_d         = 1'b0;
        x_valid_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        bits_left_d = '0;
        if (state_q == SHIFT) begin
            x_d         = shreg_q[WIDTH-1];
            x_valid_d   = 1'b1;
            bits_left_d = cnt_q;
        end
        if (state_q != IDLE) begin
            busy_d = 1'b1;
        end
        if (state_q == DONE) begin
            done_d = 1'b1;
        end
`ifdef SEQ_GEN_REPEAT_EN
        if (rep_first_q) begin
            done_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            cnt_q       <= '0;
            x_q         <= 1'b0;
            x_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bits_left_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            cnt_q       <= cnt_d;
            x_q         <= x_d;
            x_valid_q   <= x_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bits_left_q <= bits_left_d;
        end
    end

`ifdef SEQ_GEN_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            saved_word_q <= '0;
            saved_len_q  <= '0;
            rep_first_q  <= 1'b0;
        end else begin
            saved_word_q <= saved_word_d;
            saved_len_q  <= saved_len_d;
            rep_first_q  <= rep_first_d;
        end
    end
`endif

    assign X         = x_q;
    assign x_valid   = x_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bits_left = bits_left_q;

endmodule
